// File: rtl/rf_wb_sched.sv
// Write-back scheduler and pending-write scoreboard for the 32-entry integer register file.
// Optional macro RF_WB_FIXED_PRIO_EN replaces round-robin arbitration with fixed priority 0 > 1 > 2.
module rf_wb_sched #(
  parameter int ADDR_W = 64,
  parameter int N_REQ  = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_issue_valid,
  input  logic [4:0]              i_issue_rs1,
  input  logic [4:0]              i_issue_rs2,
  input  logic [4:0]              i_issue_rd,
  input  logic                    i_issue_wen,
  output logic                    o_issue_stall,
  input  logic [N_REQ-1:0]        i_wb_valid,
  input  logic [5*N_REQ-1:0]      i_wb_rd,
  input  logic [ADDR_W*N_REQ-1:0] i_wb_data,
  output logic [N_REQ-1:0]        o_wb_ready,
  output logic [4:0]              o_write_reg,
  output logic [ADDR_W-1:0]       o_writedata,
  output logic                    o_writedatasignal,
  output logic [31:0]             o_busy_vec,
  output logic                    o_err_spurious
);

  logic [31:0]       busy_q, busy_d;
  logic [4:0]        write_reg_q;
  logic [ADDR_W-1:0] writedata_q;
  logic              wen_q;
  logic              err_q;
  logic [N_REQ-1:0]  grant;
  logic              hs;
  logic [4:0]        sel_rd;
  logic [ADDR_W-1:0] sel_data;
  logic              issue_acc;

  // No bypass: a register committing this cycle still reads as busy.
  assign o_issue_stall = i_issue_valid &
                         (busy_q[i_issue_rs1] | busy_q[i_issue_rs2] | (i_issue_wen & busy_q[i_issue_rd]));
  assign issue_acc     = i_issue_valid & ~o_issue_stall & i_issue_wen & (i_issue_rd != 5'd0);

`ifdef RF_WB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    if (i_wb_valid[0])      grant[0] = 1'b1;
    else if (i_wb_valid[1]) grant[1] = 1'b1;
    else if (i_wb_valid[2]) grant[2] = 1'b1;
  end
`else
  logic [1:0] ptr_q, ptr_d;

  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] v, input logic [1:0] p);
    logic [N_REQ-1:0] r;
    r = '0;
    case (p)
      2'd1: begin
        if (v[1])      r[1] = 1'b1;
        else if (v[2]) r[2] = 1'b1;
        else if (v[0]) r[0] = 1'b1;
      end
      2'd2: begin
        if (v[2])      r[2] = 1'b1;
        else if (v[0]) r[0] = 1'b1;
        else if (v[1]) r[1] = 1'b1;
      end
      default: begin
        if (v[0])      r[0] = 1'b1;
        else if (v[1]) r[1] = 1'b1;
        else if (v[2]) r[2] = 1'b1;
      end
    endcase
    return r;
  endfunction

  assign grant = rr_pick(i_wb_valid, ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (grant[0]) ptr_d = 2'd1;
    if (grant[1]) ptr_d = 2'd2;
    if (grant[2]) ptr_d = 2'd0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ptr_q <= 2'd0;
    else          ptr_q <= ptr_d;
  end
`endif

  assign hs = |grant;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_rd   = i_wb_rd[5*k +: 5];
        sel_data = i_wb_data[ADDR_W*k +: ADDR_W];
      end
    end
  end

  // Set is applied after clear so a same-edge reissue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wen_q)     busy_d[write_reg_q] = 1'b0;
    if (issue_acc) busy_d[i_issue_rd]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q      <= '0;
      write_reg_q <= '0;
      writedata_q <= '0;
      wen_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      busy_q <= busy_d;
      wen_q  <= hs & (sel_rd != 5'd0);
      if (hs) begin
        write_reg_q <= sel_rd;
        writedata_q <= sel_data;
      end
      if (hs && (sel_rd != 5'd0) && !busy_q[sel_rd]) err_q <= 1'b1;
    end
  end

  assign o_wb_ready        = grant;
  assign o_write_reg       = write_reg_q;
  assign o_writedata       = writedata_q;
  assign o_writedatasignal = wen_q;
  assign o_busy_vec        = busy_q;
  assign o_err_spurious    = err_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Randomised scoreboard bench for rf_wb_sched against a queue/array reference model.
`timescale 1ns/1ps
module tb_rf_wb_sched;
  localparam int AW = 64;

  logic           i_clk = 1'b0;
  logic           i_rst_n;
  logic           i_issue_valid;
  logic [4:0]     i_issue_rs1, i_issue_rs2, i_issue_rd;
  logic           i_issue_wen;
  logic           o_issue_stall;
  logic [2:0]     i_wb_valid;
  logic [14:0]    i_wb_rd;
  logic [3*AW-1:0] i_wb_data;
  logic [2:0]     o_wb_ready;
  logic [4:0]     o_write_reg;
  logic [AW-1:0]  o_writedata;
  logic           o_writedatasignal;
  logic [31:0]    o_busy_vec;
  logic           o_err_spurious;

  rf_wb_sched #(.ADDR_W(AW), .N_REQ(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_issue_valid(i_issue_valid), .i_issue_rs1(i_issue_rs1), .i_issue_rs2(i_issue_rs2),
    .i_issue_rd(i_issue_rd), .i_issue_wen(i_issue_wen), .o_issue_stall(o_issue_stall),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .o_wb_ready(o_wb_ready),
    .o_write_reg(o_write_reg), .o_writedata(o_writedata), .o_writedatasignal(o_writedatasignal),
    .o_busy_vec(o_busy_vec), .o_err_spurious(o_err_spurious)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int cyc; logic [4:0] rd; logic [AW-1:0] data; } wr_t;
  wr_t expq[$];
  wr_t mon_e;

  int nvec = 0, nerr = 0, cyc = 0;

  // reference model state
  bit [31:0] m_busy, claimed;
  int        m_ptr;
  bit        m_err;
  bit        cm_v;
  logic [4:0] cm_rd;

  // stimulus state
  bit         iv, iwen;
  logic [4:0] irs1, irs2, ird;
  bit         req_v [3];
  logic [4:0] req_rd [3];
  logic [AW-1:0] req_data [3];

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_issue(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input bit w);
    iv = v; irs1 = r1; irs2 = r2; ird = rd; iwen = w;
  endtask

  task automatic set_req(input int k, input logic [4:0] rd, input logic [AW-1:0] d);
    req_v[k] = 1'b1; req_rd[k] = rd; req_data[k] = d;
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step();
    int sel;
    bit stall_e;
    bit [31:0] nb;
    logic [2:0] g;
    i_issue_valid = iv; i_issue_rs1 = irs1; i_issue_rs2 = irs2; i_issue_rd = ird; i_issue_wen = iwen;
    for (int k = 0; k < 3; k++) begin
      i_wb_valid[k]        = req_v[k];
      i_wb_rd[5*k +: 5]    = req_rd[k];
      i_wb_data[AW*k +: AW] = req_data[k];
    end
    #1;
    stall_e = iv && (m_busy[irs1] || m_busy[irs2] || (iwen && m_busy[ird]));
    sel = -1;
`ifdef RF_WB_FIXED_PRIO_EN
    for (int k = 0; k < 3; k++) if (req_v[k] && sel < 0) sel = k;
`else
    for (int i = 0; i < 3; i++) if (req_v[(m_ptr + i) % 3] && sel < 0) sel = (m_ptr + i) % 3;
`endif
    g = 3'b000;
    if (sel >= 0) g[sel] = 1'b1;
    chk("stall", 64'(o_issue_stall), 64'(stall_e));
    chk("ready", 64'(o_wb_ready), 64'(g));
    chk("busy_vec", 64'(o_busy_vec), 64'(m_busy));
    chk("err_spurious", 64'(o_err_spurious), 64'(m_err));
    @(posedge i_clk);
    cyc++;
    nb = m_busy;
    if (cm_v) begin nb[cm_rd] = 1'b0; claimed[cm_rd] = 1'b0; end
    if (iv && !stall_e && iwen && ird != 5'd0) nb[ird] = 1'b1;
    cm_v = 1'b0;
    if (sel >= 0) begin
      if (req_rd[sel] != 5'd0) begin
        if (!m_busy[req_rd[sel]]) m_err = 1'b1;
        cm_v = 1'b1; cm_rd = req_rd[sel];
        expq.push_back('{cyc, req_rd[sel], req_data[sel]});
      end
      m_ptr = (sel + 1) % 3;
      req_v[sel] = 1'b0;
    end
    m_busy = nb;
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    set_issue(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) req_v[k] = 1'b0;
    i_issue_valid = 1'b0; i_wb_valid = '0; i_wb_rd = '0; i_wb_data = '0;
    i_issue_rs1 = '0; i_issue_rs2 = '0; i_issue_rd = '0; i_issue_wen = 1'b0;
    #1;
    chk("rst_write_reg", 64'(o_write_reg), 64'd0);
    chk("rst_writedata", o_writedata, 64'd0);
    chk("rst_wen", 64'(o_writedatasignal), 64'd0);
    chk("rst_busy", 64'(o_busy_vec), 64'd0);
    chk("rst_err", 64'(o_err_spurious), 64'd0);
    chk("rst_ready", 64'(o_wb_ready), 64'd0);
    chk("rst_stall", 64'(o_issue_stall), 64'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    m_busy = '0; claimed = '0; m_ptr = 0; m_err = 1'b0; cm_v = 1'b0;
    expq.delete();
  endtask

  task automatic rand_cycles(input int n);
    bit [31:0] cand;
    int r;
    for (int c = 0; c < n; c++) begin
      set_issue($urandom_range(0, 9) < 6, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                5'($urandom_range(0, 15)), $urandom_range(0, 9) < 7);
      for (int k = 0; k < 3; k++) begin
        if (!req_v[k] && $urandom_range(0, 2) == 0) begin
          cand = m_busy & ~claimed;
          if ($urandom_range(0, 7) == 0) set_req(k, 5'd0, {$urandom, $urandom});
          else if (cand != 0) begin
            do r = $urandom_range(1, 31); while (!cand[r]);
            claimed[r] = 1'b1;
            set_req(k, 5'(r), {$urandom, $urandom});
          end
        end
      end
      step();
    end
  endtask

  // Monitor: every presented register-file write must match the next expected one.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_writedatasignal) begin
        if (expq.size() == 0) chk("unexpected_write", 64'(o_writedatasignal), 64'd0);
        else begin
          mon_e = expq.pop_front();
          chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("wr_reg", 64'(o_write_reg), 64'(mon_e.rd));
          chk("wr_data", o_writedata, mon_e.data);
        end
      end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
        mon_e = expq.pop_front();
        chk("wr_missing", 64'(o_writedatasignal), 64'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    do_reset();
    step(); step();
    // RAW hazard on x5, then write-back from requester 1
    set_issue(1, 0, 0, 5, 1); step();
    set_issue(1, 5, 0, 0, 0); step();
    set_issue(0, 0, 0, 0, 0); set_req(1, 5, 64'hDEAD); step();
    step(); step();
    // all three requesters contending continuously
    for (int r = 1; r <= 6; r++) begin set_issue(1, 0, 0, 5'(r), 1); step(); end
    set_issue(0, 0, 0, 0, 0);
    nxt = 1;
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < 3; k++)
        if (!req_v[k] && nxt <= 6) begin set_req(k, 5'(nxt), 64'(nxt) * 64'h1111); nxt++; end
      step();
    end
    step(); step();
    // write-back to x0
    set_req(2, 0, 64'h1234); step(); step(); step();
    // reissue to x7 during its commit cycle
    set_issue(1, 0, 0, 7, 1); step();
    set_issue(0, 0, 0, 0, 0); set_req(0, 7, 64'hABCD_0007); step();
    set_issue(1, 0, 0, 7, 1); step();
    step();
    set_issue(0, 0, 0, 0, 0); step();
    set_req(0, 7, 64'h7777); step(); step(); step();
    // spurious write-back to idle x9
    set_req(1, 9, 64'h9999_0000_9999); step(); step(); step();
    rand_cycles(1500);
    // asynchronous reset mid-stream with busy bits and pending requesters
    do_reset();
    rand_cycles(500);
    set_issue(0, 0, 0, 0, 0);
    for (int c = 0; c < 50 && (req_v[0] || req_v[1] || req_v[2]); c++) step();
    step(); step(); step();
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
